// File: rtl/load_store_ctrl.sv
// Load/store controller between the MEM stage and the data cache: aligns store
// lanes, extends load results, detects misalignment and aborts stuck accesses.
module load_store_ctrl #(
   parameter int MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        dmem_read,
   output logic        dmem_write,
   output logic [31:0] dmem_address,
   output logic [3:0]  dmem_byte_enable,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_resp,
   input  logic [31:0] dmem_rdata
);

   localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_lane;
   logic [2:0]    r_funct3;
   logic          r_is_store;
   logic          r_done;
   logic          r_err;
   logic [31:0]   r_rdata;
   logic          r_dmem_read;
   logic          r_dmem_write;
   logic [31:0]   r_dmem_address;
   logic [3:0]    r_dmem_be;
   logic [31:0]   r_dmem_wdata;

   logic          w_req;
   logic          w_misal;
   logic [3:0]    w_store_be;
   logic [31:0]   w_shifted;
   logic [31:0]   w_load;
   logic          w_stall;

   assign w_req = mem_read | mem_write;

   // funct3[1:0] encodes size for both loads and stores; 2'b11 has no alignment rule
   assign w_misal = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));

   always_comb begin
      w_store_be = 4'b1111;
      case (funct3[1:0])
         2'b00:   w_store_be = 4'b0001 << addr[1:0];
         2'b01:   w_store_be = 4'b0011 << addr[1:0];
         default: w_store_be = 4'b1111;
      endcase
   end

   assign w_shifted = dmem_rdata >> {r_lane, 3'b000};

   always_comb begin
      w_load = w_shifted;
      case (r_funct3)
         3'b000:  w_load = {{24{w_shifted[7]}},  w_shifted[7:0]};
         3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load = {24'd0, w_shifted[7:0]};
         3'b101:  w_load = {16'd0, w_shifted[15:0]};
         default: w_load = w_shifted;
      endcase
   end

   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         IDLE:    w_stall = w_req && !w_misal;
         ACCESS:  w_stall = 1'b1;
         default: w_stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_lane         <= '0;
         r_funct3       <= '0;
         r_is_store     <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_rdata        <= '0;
         r_dmem_read    <= 1'b0;
         r_dmem_write   <= 1'b0;
         r_dmem_address <= '0;
         r_dmem_be      <= '0;
         r_dmem_wdata   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               r_err  <= 1'b0;
               if (w_req) begin
                  r_lane     <= addr[1:0];
                  r_funct3   <= funct3;
                  r_is_store <= mem_write;
                  r_cnt      <= '0;
                  if (w_misal) begin
                     r_state <= DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     // a simultaneous read and write is a store
                     r_state        <= ACCESS;
                     r_dmem_read    <= !mem_write;
                     r_dmem_write   <= mem_write;
                     r_dmem_address <= {addr[31:2], 2'b00};
                     r_dmem_be      <= mem_write ? w_store_be : 4'b1111;
                     r_dmem_wdata   <= wdata << {addr[1:0], 3'b000};
                  end
               end
            end
            ACCESS: begin
               if (dmem_resp) begin
                  r_state      <= DONE;
                  r_done       <= 1'b1;
                  r_dmem_read  <= 1'b0;
                  r_dmem_write <= 1'b0;
                  if (!r_is_store) r_rdata <= w_load;
               end else if (r_cnt == CW'(MAX_WAIT - 1)) begin
                  // counter would reach MAX_WAIT this edge: abort
                  r_state      <= DONE;
                  r_done       <= 1'b1;
                  r_err        <= 1'b1;
                  r_rdata      <= '0;
                  r_dmem_read  <= 1'b0;
                  r_dmem_write <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_err   <= 1'b0;
            end
         endcase
      end
   end

   assign stall            = w_stall;
   assign done             = r_done;
   assign err              = r_err;
   assign rdata            = r_rdata;
   assign dmem_read        = r_dmem_read;
   assign dmem_write       = r_dmem_write;
   assign dmem_address     = r_dmem_address;
   assign dmem_byte_enable = r_dmem_be;
   assign dmem_wdata       = r_dmem_wdata;

endmodule
